// File: rtl/led7seg_scan_mux.sv
// Multiplexed 7-segment scan driver with per-digit dead time, 16-level PWM and a frame-coherent shadow buffer.
// Optional LED7SEG_BLINK_EN adds a blink_mask input that darkens masked digits for 32 of every 64 frames.
module led7seg_scan_mux #(
  parameter int CLK_FREQ       = 10_000_000,
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_HZ     = 100,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int POS_ACTIVE_LOW = 1,
  localparam int AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk_in,
  input  logic                  init,
  input  logic                  wr_en,
  input  logic [AW-1:0]         addr,
  input  logic [3:0]            data,
  input  logic                  dp,
  input  logic                  blank,
  input  logic [3:0]            bright,
`ifdef LED7SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0] blink_mask,
`endif
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] pos,
  output logic                  frame_sync
);

  localparam int DIGIT_TICKS = CLK_FREQ / (REFRESH_HZ * NUM_DIGITS);
  localparam int ACTIVE      = DIGIT_TICKS - BLANK_CYCLES;
  localparam int CW          = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] POS_OFF = (POS_ACTIVE_LOW != 0) ? '1 : '0;

  if (ACTIVE < 16 || NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_cfg
    $error("led7seg_scan_mux: ACTIVE must be >= 16 and NUM_DIGITS within 1..16");
  end

  typedef enum logic [1:0] {PH_BLANK, PH_ON, PH_OFF} phase_t;

  logic [5:0]            wbuf   [NUM_DIGITS];  // {blank, dp, data}
  logic [5:0]            shadow [NUM_DIGITS];
  logic [CW-1:0]         cnt;
  logic [AW-1:0]         digit;
  logic [3:0]            bright_l;
  logic                  frame_start;
  logic                  slot_end;
  logic                  last_digit;
  phase_t                phase;
  logic [31:0]           on_len;
  logic [5:0]            cur;
  logic                  dark;
  logic [7:0]            seg_nxt;
  logic [NUM_DIGITS-1:0] pos_nxt;

  function automatic logic [6:0] char_rom(input logic [3:0] code);
    case (code)
      4'h0: char_rom = 7'h3F;
      4'h1: char_rom = 7'h06;
      4'h2: char_rom = 7'h5B;
      4'h3: char_rom = 7'h4F;
      4'h4: char_rom = 7'h66;
      4'h5: char_rom = 7'h6D;
      4'h6: char_rom = 7'h7D;
      4'h7: char_rom = 7'h07;
      4'h8: char_rom = 7'h7F;
      4'h9: char_rom = 7'h6F;
      4'hA: char_rom = 7'h77;
      4'hB: char_rom = 7'h7C;
      4'hC: char_rom = 7'h39;
      4'hD: char_rom = 7'h5E;
      4'hE: char_rom = 7'h79;
      default: char_rom = 7'h71;
    endcase
  endfunction

  assign frame_start = (cnt == '0) && (digit == '0);
  assign slot_end    = (cnt == CW'(DIGIT_TICKS - 1));
  assign last_digit  = (digit == AW'(NUM_DIGITS - 1));

`ifdef LED7SEG_BLINK_EN
  logic [5:0]            frame_cnt;
  logic [NUM_DIGITS-1:0] mask_l;

  // frame_cnt advances on the last tick so it is stable for the whole next frame
  always_ff @(posedge clk_in) begin
    if (init) begin
      frame_cnt <= '0;
      mask_l    <= '0;
    end else begin
      if (frame_start) mask_l <= blink_mask;
      if (slot_end && last_digit) frame_cnt <= frame_cnt + 6'd1;
    end
  end
`endif

  always_comb begin
    on_len  = ((32'(bright_l) + 32'd1) * 32'(ACTIVE)) >> 4;
    cur     = shadow[digit];
    dark    = cur[5];
`ifdef LED7SEG_BLINK_EN
    if (mask_l[digit] && frame_cnt[5]) dark = 1'b1;
`endif
    if (32'(cnt) < 32'(BLANK_CYCLES))
      phase = PH_BLANK;
    else if (32'(cnt) < 32'(BLANK_CYCLES) + on_len)
      phase = PH_ON;
    else
      phase = PH_OFF;
    seg_nxt = '0;
    pos_nxt = '0;
    if (phase == PH_ON && !dark) begin
      seg_nxt        = {cur[4], char_rom(cur[3:0])};
      pos_nxt[digit] = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (init) begin
      cnt        <= '0;
      digit      <= '0;
      bright_l   <= '0;
      frame_sync <= 1'b0;
      seg        <= SEG_OFF;
      pos        <= POS_OFF;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        wbuf[i]   <= 6'b10_0000;
        shadow[i] <= 6'b10_0000;
      end
    end else begin
      frame_sync <= frame_start;
      seg        <= seg_nxt ^ SEG_OFF;
      pos        <= pos_nxt ^ POS_OFF;
      if (slot_end) begin
        cnt   <= '0;
        digit <= last_digit ? '0 : digit + AW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
      // copy uses pre-write contents, so a write on this edge lands one frame later
      if (frame_start) begin
        for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= wbuf[i];
        bright_l <= bright;
      end
      if (wr_en && (32'(addr) < 32'(NUM_DIGITS))) wbuf[addr] <= {blank, dp, data};
    end
  end

endmodule
